// File: rtl/proc_seq_pkg.sv
// Shared definitions for the proc instruction sequencer: state encoding,
// opcode constants and watchdog sizing.
package proc_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned OPC_W      = 3;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned WDOG_W     = 4;
  localparam int unsigned WDOG_LIMIT = 15;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_I1,
    S_I2,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } seq_state_e;

  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  // Busy covers everything except the two parked states.
  function automatic logic is_active(input seq_state_e s);
    return !((s == S_IDLE) || (s == S_HALT));
  endfunction

endpackage

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches words from a synchronous program ROM and
// feeds proc's DIN with a one-cycle Run pulse, waiting for Done in between.
// Optional feature macro: PROC_SEQ_WATCHDOG_EN (bounded WAIT with Fault).
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic [CNT_W-1:0]  InstrCount,
  output logic              Fault
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iword_q, iword_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              mvi_q, mvi_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [OPC_W-1:0]  opc_c;

`ifdef PROC_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;
`endif

  assign opc_c = MemData[DATA_W-1 -: OPC_W];

  // Next-state, datapath register and registered-output computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iword_d = iword_q;
    imm_d   = imm_q;
    mvi_d   = mvi_q;
    icnt_d  = icnt_q;
`ifdef PROC_SEQ_WATCHDOG_EN
    wdog_d  = wdog_q;
    fault_d = fault_q;
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_F1;
          pc_d    = '0;
          icnt_d  = '0;
`ifdef PROC_SEQ_WATCHDOG_EN
          fault_d = 1'b0;
`endif
        end
      end
      S_F1: state_d = S_F2;
      S_F2: begin
        iword_d = MemData;
        pc_d    = pc_q + ADDR_W'(1);
        mvi_d   = (opc_c == OP_MVI);
        if (opc_c == OP_HALT)     state_d = S_HALT;
        else if (opc_c == OP_MVI) state_d = S_I1;
        else                      state_d = S_ISSUE;
      end
      S_I1: state_d = S_I2;
      S_I2: begin
        imm_d   = MemData;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef PROC_SEQ_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (Done) begin
          icnt_d  = icnt_q + CNT_W'(1);
          state_d = S_F1;
        end
`ifdef PROC_SEQ_WATCHDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the upcoming state.
    run_d    = (state_d == S_ISSUE);
    din_d    = ((state_d == S_WAIT) && mvi_d) ? imm_d : iword_d;
    busy_d   = is_active(state_d);
    halted_d = (state_d == S_HALT);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      iword_q  <= '0;
      imm_q    <= '0;
      mvi_q    <= 1'b0;
      icnt_q   <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iword_q  <= iword_d;
      imm_q    <= imm_d;
      mvi_q    <= mvi_d;
      icnt_q   <= icnt_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

`ifdef PROC_SEQ_WATCHDOG_EN
  // Watchdog counter and sticky fault flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign MemAddr    = pc_q;
  assign DIN        = din_q;
  assign Run        = run_q;
  assign Busy       = busy_q;
  assign Halted     = halted_q;
  assign InstrCount = icnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a behavioural ROM and proc model.
module tb_proc_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 9;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Halted;
  logic [15:0]       InstrCount;
  logic              Fault;

  int errors = 0;
  int checks = 0;

  proc_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .DIN        (DIN),
    .Run        (Run),
    .Done       (Done),
    .Busy       (Busy),
    .Halted     (Halted),
    .InstrCount (InstrCount),
    .Fault      (Fault)
  );

  always #5 Clock = ~Clock;

  // Synchronous program ROM: data valid one cycle after the address.
  logic [DATA_W-1:0] rom [32];
  always @(posedge Clock) MemData <= rom[MemAddr];

  // Minimal proc model: mv/mvi finish the cycle after Run, add/sub 3 after.
  logic [8:0] ir_m;
  logic [8:0] regs [8];
  logic       done_m = 1'b0;
  logic       hold_low = 1'b0;
  int         wcnt = 0;
  assign Done = done_m & ~hold_low;

  always @(posedge Clock) begin
    if (Reset) begin
      done_m <= 1'b0;
      wcnt   <= 0;
      ir_m   <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      done_m <= 1'b0;
      if (Done) begin
        case (ir_m[8:6])
          3'b000:  regs[ir_m[5:3]] <= regs[ir_m[2:0]];
          3'b001:  regs[ir_m[5:3]] <= DIN;
          3'b010:  regs[ir_m[5:3]] <= regs[ir_m[5:3]] + regs[ir_m[2:0]];
          3'b011:  regs[ir_m[5:3]] <= regs[ir_m[5:3]] - regs[ir_m[2:0]];
          default: ;
        endcase
      end
      if (Run) begin
        ir_m <= DIN;
        if (DIN[8:6] == 3'b000 || DIN[8:6] == 3'b001) done_m <= 1'b1;
        else wcnt <= 2;
      end else if (wcnt != 0) begin
        wcnt <= wcnt - 1;
        if (wcnt == 1) done_m <= 1'b1;
      end
    end
  end

  // Run pulse and high-cycle counters.
  int run_pulses = 0;
  int run_cycles = 0;
  bit run_prev = 1'b0;
  always @(posedge Clock) begin
    if (Run === 1'b1) run_cycles <= run_cycles + 1;
    if (Run === 1'b1 && !run_prev) run_pulses <= run_pulses + 1;
    run_prev <= (Run === 1'b1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int p0, c0;

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    repeat (3) tick();
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_din",     32'(DIN),     32'd0);
    chk("rst_run",     32'(Run),     32'd0);
    chk("rst_busy",    32'(Busy),    32'd0);
    chk("rst_halted",  32'(Halted),  32'd0);
    chk("rst_icnt",    32'(InstrCount), 32'd0);
    chk("rst_fault",   32'(Fault),   32'd0);
    Reset = 1'b0;
    tick();
    chk("idle_busy", 32'(Busy), 32'd0);

    // mvi R0,#5 ; halt
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h1C0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t1_f1_busy", 32'(Busy),    32'd1);
    chk("t1_f1_addr", 32'(MemAddr), 32'd0);
    chk("t1_f1_run",  32'(Run),     32'd0);
    repeat (3) tick();
    chk("t1_i2_run",  32'(Run),     32'd0);
    tick();
    chk("t1_issue_run", 32'(Run), 32'd1);
    chk("t1_issue_din", 32'(DIN), 32'h040);
    tick();
    chk("t1_wait_run", 32'(Run), 32'd0);
    chk("t1_wait_din", 32'(DIN), 32'h005);
    tick();
    chk("t1_icnt1", 32'(InstrCount), 32'd1);
    chk("t1_addr2", 32'(MemAddr),    32'd2);
    tick();
    chk("t1_f2_halted", 32'(Halted), 32'd0);
    tick();
    chk("t1_halted",  32'(Halted), 32'd1);
    chk("t1_busy",    32'(Busy),   32'd0);
    chk("t1_din",     32'(DIN),    32'h1C0);
    chk("t1_icnt",    32'(InstrCount), 32'd1);
    chk("t1_r0",      32'(regs[0]), 32'd5);

    // mvi R0,#5 ; mv R1,R0 ; add R0,R1 ; halt  (restart from HALT)
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h008; rom[3] = 9'h081; rom[4] = 9'h1C0;
    p0 = run_pulses;
    c0 = run_cycles;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t2_restart_halted", 32'(Halted), 32'd0);
    chk("t2_restart_icnt",   32'(InstrCount), 32'd0);
    repeat (10) tick();
    chk("t2_add_f1_addr", 32'(MemAddr),    32'd3);
    chk("t2_add_f1_icnt", 32'(InstrCount), 32'd2);
    repeat (6) tick();
    chk("t2_add_done_addr", 32'(MemAddr),    32'd4);
    chk("t2_add_done_icnt", 32'(InstrCount), 32'd3);
    tick();
    chk("t2_pre_halt", 32'(Halted), 32'd0);
    tick();
    chk("t2_halted",   32'(Halted), 32'd1);
    chk("t2_pulses",   32'(run_pulses - p0), 32'd3);
    chk("t2_runcyc",   32'(run_cycles - c0), 32'd3);
    chk("t2_r0",       32'(regs[0]), 32'd10);
    chk("t2_r1",       32'(regs[1]), 32'd5);

    // Whole ROM of mv R1,R0: PC wraps, then reset mid-WAIT
    for (int i = 0; i < 32; i++) rom[i] = 9'h008;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (128) tick();
    chk("t3_wrap_addr", 32'(MemAddr),    32'd0);
    chk("t3_wrap_icnt", 32'(InstrCount), 32'd32);
    chk("t3_wrap_busy", 32'(Busy),       32'd1);
    repeat (4) tick();
    chk("t3_post_addr", 32'(MemAddr),    32'd1);
    chk("t3_post_icnt", 32'(InstrCount), 32'd33);
    repeat (2) tick();
    chk("t3_issue_run", 32'(Run), 32'd1);
    tick();
    chk("t3_wait_run",  32'(Run),  32'd0);
    chk("t3_wait_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    chk("t3_rst_busy", 32'(Busy),       32'd0);
    chk("t3_rst_run",  32'(Run),        32'd0);
    chk("t3_rst_icnt", 32'(InstrCount), 32'd0);
    chk("t3_rst_addr", 32'(MemAddr),    32'd0);
    Reset = 1'b0;
    tick();

    // add R0,R1 ; halt  with Start held high through WAIT
    rom[0] = 9'h081; rom[1] = 9'h1C0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    Start = 1'b1;
    tick();
    chk("t4_wait_busy", 32'(Busy),       32'd1);
    chk("t4_wait_addr", 32'(MemAddr),    32'd1);
    chk("t4_wait_icnt", 32'(InstrCount), 32'd0);
    tick();
    Start = 1'b0;
    tick();
    chk("t4_f1_addr", 32'(MemAddr),    32'd1);
    chk("t4_f1_icnt", 32'(InstrCount), 32'd1);
    repeat (2) tick();
    chk("t4_halted", 32'(Halted), 32'd1);

    // Done held low while waiting on an add
    hold_low = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
`ifdef PROC_SEQ_WATCHDOG_EN
    repeat (14) tick();
    chk("t5_wd_pre_halted", 32'(Halted), 32'd0);
    chk("t5_wd_pre_fault",  32'(Fault),  32'd0);
    tick();
    chk("t5_wd_halted", 32'(Halted), 32'd1);
    chk("t5_wd_fault",  32'(Fault),  32'd1);
    chk("t5_wd_busy",   32'(Busy),   32'd0);
`else
    repeat (20) tick();
    chk("t5_nowd_busy",   32'(Busy),       32'd1);
    chk("t5_nowd_halted", 32'(Halted),     32'd0);
    chk("t5_nowd_fault",  32'(Fault),      32'd0);
    chk("t5_nowd_icnt",   32'(InstrCount), 32'd0);
`endif
    hold_low = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Instruction sequencer that feeds the 9-bit `proc` datapath from a synchronous program ROM. It fetches instruction words, plus the immediate word for `mvi`. It presents each word on `proc`'s `DIN` with a one-cycle `Run` pulse, then waits for `Done` before fetching the next instruction. It sits between the program ROM and `proc` and replaces the manual `Run`/`DIN` switches used so far.

## Interface
Parameters:
- `ADDR_W`, default 5: ROM address width (program length 2^ADDR_W words).
- `DATA_W`, default 9: instruction/data word width (matches `proc`).

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin execution at address 0; sampled only in IDLE or HALT.
- `MemAddr`  out  ADDR_W  ROM address, equal to PC (registered).
- `MemData`  in  DATA_W  ROM read data, valid one cycle after `MemAddr`.
- `DIN`  out  DATA_W  to `proc.DIN`.
- `Run`  out  1  to `proc.Run`.
- `Done`  in  1  from `proc.Done`.
- `Busy`  out  1  high in every state except IDLE and HALT.
- `Halted`  out  1  high in HALT.
- `InstrCount`  out  16  instructions retired since `Start`.
- `Fault`  out  1  watchdog fault (only with `PROC_SEQ_WATCHDOG_EN`).

## Operation
- Opcode = word[8:6] (`I`). `001` = mvi (two words). `111` = HALT (consumed by the sequencer, never issued). All others are single-word instructions.
- States: IDLE, F1, F2, I1, I2, ISSUE, WAIT, HALT.
- IDLE/HALT + `Start`=1: PC←0, InstrCount←0, Fault←0, next state F1.
- F1: `MemAddr`=PC; ROM latency cycle.
- F2: IWord←MemData; PC←PC+1. Next state: HALT if I=111; I1 if I=001; otherwise ISSUE.
- I1: ROM latency cycle for the immediate.
- I2: ImmWord←MemData; PC←PC+1; next state ISSUE.
- ISSUE: `Run`=1 and `DIN`=IWord for exactly one cycle; next state WAIT.
- WAIT: `Run`=0. `DIN`=ImmWord for mvi, otherwise IWord.
  - `Done`=1: InstrCount←InstrCount+1, next state F1.
  - `Done`=0: stay in WAIT.
- `DIN` in all other states = IWord.
- PC wraps from 2^ADDR_W−1 to 0 with no flag, including mid-mvi (immediate read from address 0).
- InstrCount wraps at 16 bits.
- `Start` in any other state is ignored.
- `Done` in any state other than WAIT is ignored.

## Timing
- Reset values: state IDLE, PC 0, `MemAddr` 0, IWord/ImmWord 0, `DIN` 0, `Run` 0, `Busy` 0, `Halted` 0, InstrCount 0, `Fault` 0.
- Reset mid-instruction returns to IDLE on the next edge with `Run` deasserted. `proc` must be reset in the same cycle (system-level requirement).
- `Run` pulses for exactly one cycle per instruction. It is never asserted while `proc` is busy.
- Fetch overhead:
  - 2 cycles for a single-word instruction (F1, F2).
  - 4 cycles for mvi (F1, F2, I1, I2).
- `proc` latches IR during ISSUE.
  - mv/mvi: `Done` in the cycle after ISSUE, so WAIT lasts 1 cycle; mvi reads the immediate from `DIN` in that cycle.
  - add/sub: `Done` 3 cycles after ISSUE.
- Cycles per instruction: mv 4, mvi 6, add/sub 6.
- HALT is entered 2 cycles after its word is addressed; `Halted` rises on entry.

## Configuration
- `PROC_SEQ_WATCHDOG_EN` defined: a 4-bit counter clears on entry to WAIT and increments each WAIT cycle. If `Done` is still 0 after 15 WAIT cycles, set `Fault`=1 and go to HALT. `Fault` holds until the next `Start` or `Reset`.
- `PROC_SEQ_WATCHDOG_EN` not defined: no counter, WAIT is unbounded, and `Fault` is tied to 0.

## Structure
- Shared package `proc_seq_pkg`:
  - state encoding;
  - opcode constants `OP_MV`=000, `OP_MVI`=001, `OP_ADD`=010, `OP_SUB`=011, `OP_HALT`=111;
  - watchdog limit constant 15.
- IWord and ImmWord may instantiate the existing `regn`. No new sub-module is required.

## Test plan
- ROM {0x040, 0x005, 0x1C0} (mvi R0,#5; halt) + `Start` → `Run` high 5 cycles after `Start`, `DIN`=0x040. Next cycle `DIN`=0x005. `Halted`=1, InstrCount=1, R0=5.
- ROM {0x040, 0x005, 0x008, 0x081, 0x1C0} → `Run` pulses exactly 3 times, InstrCount=3, R0=10, R1=5; add takes 6 cycles from its F1.
- Fill the ROM (32 words) with 0x008; after 32 retirements `MemAddr` wraps to 0 and execution continues. Then assert `Reset` mid-WAIT → next cycle IDLE, `Run`=0, InstrCount=0.
- `Start` held high during WAIT → no restart; PC and InstrCount unaffected.
- With `PROC_SEQ_WATCHDOG_EN`, `Done` forced low → `Fault`=1 and `Halted`=1 exactly 15 cycles after entering WAIT. Without the macro → remains in WAIT, `Fault`=0.
